// File: rtl/ecc_mem_scrubber.sv
// Background SEC-DED(39,32) memory scrubber.
// Sweeps DEPTH words, corrects single-bit errors by write-back and counts/flags
// uncorrectable ones. The core always wins the memory port; the scrubber owns it
// only while scrub_active is high.
module ecc_mem_scrubber #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned SCRUB_GAP = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             scrub_en,
    input  logic             core_busy,
    input  logic [38:0]      mem_rd,
    output logic [31:0]      mem_addr,
    output logic [38:0]      mem_wd,
    output logic             mem_we,
    output logic             scrub_active,
    output logic             sweep_done,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count,
    output logic [31:0]      last_err_addr,
    output logic             err_irq
);

    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned GAP_W    = $clog2(SCRUB_GAP + 1) + 1;
    localparam int unsigned GAP_LAST = (SCRUB_GAP > 0) ? SCRUB_GAP - 1 : 0;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StRead,
        StCheck,
        StWrite
    } state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [GAP_W-1:0]   gap_q;
    logic [38:0]        rd_q;
    logic [38:0]        wd_q;
    logic               abort_q;
    logic               sweep_done_q;
    logic [CNT_W-1:0]   corr_q;
    logic [CNT_W-1:0]   uncorr_q;
    logic [31:0]        last_err_q;
    logic               irq_q;

    logic [5:0]         syn;
    logic               ov;
    logic               is_clean;
    logic               is_single;
    logic [38:0]        corrected;
    logic               ptr_last;
    logic [PTR_W-1:0]   ptr_next;
    logic               gap_done;
    logic               wr_fire;
    state_e             after_word;

    // Syndrome decode of the word captured in READ
    always_comb begin
        syn = '0;
        for (int p = 1; p < 39; p++) begin
            for (int k = 0; k < 6; k++) begin
                if (((p >> k) & 1) == 1) begin
                    syn[k] = syn[k] ^ rd_q[p];
                end
            end
        end
        ov        = ^rd_q;
        is_clean  = !ov && (syn == 6'd0);
        is_single = ov && (syn <= 6'd38);
        // syn == 0 with ov set means only the overall parity bit flipped
        corrected = rd_q ^ (39'd1 << syn);
    end

    // Word-completion bookkeeping: pointer wrap and where to go next
    always_comb begin
        ptr_last = (ptr_q == PTR_W'(DEPTH - 1));
        ptr_next = ptr_last ? '0 : ptr_q + PTR_W'(1);
        gap_done = (gap_q >= GAP_W'(GAP_LAST));
        if (!scrub_en) begin
            after_word = StIdle;
        end else if ((SCRUB_GAP == 0) && !core_busy) begin
            after_word = StRead;
        end else begin
            after_word = StGap;
        end
    end

    // Scrub sequencer with counters and status registers
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gap_q        <= '0;
            rd_q         <= '0;
            wd_q         <= '0;
            abort_q      <= 1'b0;
            sweep_done_q <= 1'b0;
            corr_q       <= '0;
            uncorr_q     <= '0;
            last_err_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (scrub_en) begin
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (!scrub_en) begin
                        state_q <= StIdle;
                        gap_q   <= '0;
                    end else if (gap_done) begin
                        if (!core_busy) begin
                            state_q <= StRead;
                            gap_q   <= '0;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                StRead: begin
                    rd_q    <= mem_rd;
                    abort_q <= 1'b0;
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (is_single) begin
                        wd_q    <= corrected;
                        // Core touched memory since our read: data may be stale
                        abort_q <= core_busy;
                        state_q <= StWrite;
                    end else begin
                        if (!is_clean) begin
                            if (uncorr_q != '1) begin
                                uncorr_q <= uncorr_q + CNT_W'(1);
                            end
                            last_err_q <= 32'(ptr_q);
                            irq_q      <= 1'b1;
                        end
                        ptr_q        <= ptr_next;
                        sweep_done_q <= ptr_last;
                        state_q      <= after_word;
                    end
                end
                StWrite: begin
                    if (core_busy) begin
                        abort_q <= 1'b1;
                    end else if (abort_q) begin
                        abort_q <= 1'b0;
                        state_q <= StRead;
                    end else begin
                        if (corr_q != '1) begin
                            corr_q <= corr_q + CNT_W'(1);
                        end
                        last_err_q   <= 32'(ptr_q);
                        ptr_q        <= ptr_next;
                        sweep_done_q <= ptr_last;
                        state_q      <= after_word;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Port drive: write only in an uncontested, non-aborted WRITE cycle
    assign wr_fire       = (state_q == StWrite) && !core_busy && !abort_q;
    assign scrub_active  = (state_q == StRead) || wr_fire;
    assign mem_we        = wr_fire;
    assign mem_addr      = scrub_active ? 32'(ptr_q) : 32'd0;
    assign mem_wd        = wr_fire ? wd_q : 39'd0;
    assign sweep_done    = sweep_done_q;
    assign corr_count    = corr_q;
    assign uncorr_count  = uncorr_q;
    assign last_err_addr = last_err_q;
    assign err_irq       = irq_q;

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Scoreboard bench for ecc_mem_scrubber: expected write-backs are queued by the
// stimulus thread and retired by an independent write monitor.
module tb_ecc_mem_scrubber;

    typedef struct packed {
        logic [31:0] addr;
        logic [38:0] wd;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        scrub_en = 1'b0;
    logic        core_busy = 1'b0;
    logic [38:0] mem_rd;
    logic [31:0] mem_addr;
    logic [38:0] mem_wd;
    logic        mem_we;
    logic        scrub_active;
    logic        sweep_done;
    logic [15:0] corr_count;
    logic [15:0] uncorr_count;
    logic [31:0] last_err_addr;
    logic        err_irq;

    // Second instance with narrow counters to exercise saturation
    logic        scrub_en2 = 1'b0;
    logic        busy2 = 1'b0;
    logic [38:0] mem_rd2;
    logic [31:0] mem_addr2;
    logic [38:0] mem_wd2;
    logic        mem_we2;
    logic        scrub_active2;
    logic        sweep_done2;
    logic [1:0]  corr_count2;
    logic [1:0]  uncorr_count2;
    logic [31:0] last_err_addr2;
    logic        err_irq2;

    logic [38:0] mem [32];
    logic [38:0] mem2 [4];
    logic        tb_wr = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [38:0] tb_data = '0;

    wr_t         exp_q[$];
    int          sd_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          we_seen = 0;
    logic [38:0] good;
    bit          hit;

    always #5 clk = ~clk;

    ecc_mem_scrubber #(.DEPTH(32), .SCRUB_GAP(0), .CNT_W(16)) dut (
        .clk(clk), .rst_in(rst_in), .scrub_en(scrub_en), .core_busy(core_busy),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
        .scrub_active(scrub_active), .sweep_done(sweep_done), .corr_count(corr_count),
        .uncorr_count(uncorr_count), .last_err_addr(last_err_addr), .err_irq(err_irq)
    );

    ecc_mem_scrubber #(.DEPTH(4), .SCRUB_GAP(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_in(rst_in), .scrub_en(scrub_en2), .core_busy(busy2),
        .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_wd(mem_wd2), .mem_we(mem_we2),
        .scrub_active(scrub_active2), .sweep_done(sweep_done2), .corr_count(corr_count2),
        .uncorr_count(uncorr_count2), .last_err_addr(last_err_addr2), .err_irq(err_irq2)
    );

    // Reference SEC-DED encoder: data in non-power-of-two positions 3..38
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] w;
        logic        par;
        int          j;
        w = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[p] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int p = 1; p < 39; p++) begin
                if ((((p >> k) & 1) == 1) && (p != (1 << k))) par = par ^ w[p];
            end
            w[1 << k] = par;
        end
        w[0] = ^w[38:1];
        return w;
    endfunction

    assign mem_rd  = mem[mem_addr[4:0]];
    assign mem_rd2 = mem2[mem_addr2[1:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[4:0]] <= mem_wd;
        else if (tb_wr) mem[tb_addr] <= tb_data;
    end

    always @(posedge clk) begin
        if (!rst_in) begin
            for (int i = 0; i < 4; i++) begin
                mem2[i] <= encode(32'h1234_0000 + 32'(i)) ^ (39'd1 << (i * 3 + 1));
            end
        end else if (mem_we2) begin
            mem2[mem_addr2[1:0]] <= mem_wd2;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every write-back must match the oldest queued expectation
    always @(negedge clk) begin
        cyc++;
        if (sweep_done) sd_q.push_back(cyc);
        if (rst_in && mem_we) begin
            wr_t e;
            we_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL wb_unexpected: write at addr %0d data 0x%0h, none expected",
                         mem_addr, mem_wd);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 64'(mem_addr), 64'(e.addr));
                check("wb_data", 64'(mem_wd), 64'(e.wd));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inject(input logic [4:0] a, input logic [38:0] w);
        @(negedge clk);
        tb_addr = a;
        tb_data = w;
        tb_wr   = 1'b1;
        @(posedge clk);
        #1 tb_wr = 1'b0;
    endtask

    task automatic pause();
        @(negedge clk);
        scrub_en = 1'b0;
        cycles(6);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [38:0] w);
        wr_t e;
        e.addr = a;
        e.wd   = w;
        exp_q.push_back(e);
    endtask

    initial begin
        good = encode(32'hAAAA_AAAA);
        for (int i = 0; i < 32; i++) inject(5'(i), good);
        @(negedge clk);
        check("reset_active", 64'(scrub_active), 64'd0);
        check("reset_we", 64'(mem_we), 64'd0);
        check("reset_corr", 64'(corr_count), 64'd0);
        check("reset_irq", 64'(err_irq), 64'd0);
        rst_in = 1'b1;

        // Clean sweep: no writes, sweep_done every 64 cycles
        scrub_en = 1'b1;
        cycles(200);
        check("clean_sweeps_seen", 64'(sd_q.size() >= 2), 64'd1);
        if (sd_q.size() >= 2) check("sweep_period", 64'(sd_q[1] - sd_q[0]), 64'd64);
        check("clean_no_we", 64'(we_seen), 64'd0);
        check("clean_corr", 64'(corr_count), 64'd0);
        check("clean_uncorr", 64'(uncorr_count), 64'd0);

        // Single error at addr 3, bit 5
        pause();
        inject(5'd3, good ^ (39'd1 << 5));
        expect_wr(32'd3, good);
        scrub_en = 1'b1;
        cycles(140);
        check("se_corr", 64'(corr_count), 64'd1);
        check("se_last", 64'(last_err_addr), 64'd3);
        check("se_irq", 64'(err_irq), 64'd0);

        // Double error at addr 7, bits 5 and 9
        pause();
        inject(5'd7, good ^ (39'd1 << 5) ^ (39'd1 << 9));
        scrub_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (uncorr_count != 16'd0) hit = 1'b1;
        end
        check("de_detected", 64'(hit), 64'd1);
        check("de_uncorr", 64'(uncorr_count), 64'd1);
        check("de_last", 64'(last_err_addr), 64'd7);
        check("de_irq", 64'(err_irq), 64'd1);
        pause();
        inject(5'd7, good);
        scrub_en = 1'b1;
        cycles(140);
        check("de_irq_sticky", 64'(err_irq), 64'd1);
        check("de_uncorr_hold", 64'(uncorr_count), 64'd1);
        check("de_corr_hold", 64'(corr_count), 64'd1);

        // Parity-bit-only error at addr 3
        pause();
        inject(5'd3, good ^ 39'd1);
        expect_wr(32'd3, good);
        scrub_en = 1'b1;
        cycles(140);
        check("p0_corr", 64'(corr_count), 64'd2);
        check("p0_last", 64'(last_err_addr), 64'd3);

        // Core busy during CHECK forces abort and re-read
        pause();
        inject(5'd3, good ^ (39'd1 << 20));
        expect_wr(32'd3, good);
        scrub_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (scrub_active && !mem_we && mem_addr == 32'd3) hit = 1'b1;
        end
        check("busy_read_seen", 64'(hit), 64'd1);
        core_busy = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 core_busy = 1'b0;
        @(negedge clk);
        check("busy_abort_we", 64'(mem_we), 64'd0);
        check("busy_abort_active", 64'(scrub_active), 64'd0);
        @(negedge clk);
        check("busy_reread_active", 64'(scrub_active), 64'd1);
        check("busy_reread_addr", 64'(mem_addr), 64'd3);
        cycles(140);
        check("busy_corr", 64'(corr_count), 64'd3);

        // Reset asserted during a write-back
        pause();
        inject(5'd5, good ^ (39'd1 << 10));
        scrub_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (mem_we) hit = 1'b1;
        end
        check("rst_write_seen", 64'(hit), 64'd1);
        rst_in = 1'b0;
        #1;
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_active", 64'(scrub_active), 64'd0);
        check("rst_corr", 64'(corr_count), 64'd0);
        check("rst_uncorr", 64'(uncorr_count), 64'd0);
        check("rst_last", 64'(last_err_addr), 64'd0);
        check("rst_irq", 64'(err_irq), 64'd0);
        cycles(2);
        expect_wr(32'd5, good);
        rst_in = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (scrub_active) hit = 1'b1;
        end
        check("rst_restart_seen", 64'(hit), 64'd1);
        check("rst_restart_addr", 64'(mem_addr), 64'd0);
        cycles(140);
        check("rst_after_corr", 64'(corr_count), 64'd1);
        check("rst_after_last", 64'(last_err_addr), 64'd5);

        // Saturation: four corrections into a 2-bit counter
        scrub_en2 = 1'b1;
        cycles(40);
        check("sat_corr", 64'(corr_count2), 64'd3);
        check("sat_uncorr", 64'(uncorr_count2), 64'd0);
        cycles(40);
        check("sat_corr_hold", 64'(corr_count2), 64'd3);

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
